// File: rtl/chien_search.sv
// Chien search for a GF(2^13) BCH decoder: loads sigma(x) one coefficient per beat,
// then tests one codeword position per cycle, highest position first.
module chien_search #(
  parameter int M    = 13,
  parameter int T    = 8,
  parameter int N    = 8191,
  parameter int DEGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_valid,
  input  logic [M-1:0]    load_coef,
  input  logic [DEGW-1:0] deg_in,
  output logic            load_ready,
  output logic            err_valid,
  output logic            err_flag,
  output logic [M-1:0]    err_pos,
  output logic            done,
  output logic            fail,
  output logic [1:0]      state
);

  localparam int Q  = (1 << M) - 1;
  localparam int BW = $clog2(T + 1);
  localparam logic [M-1:0]    POLY   = M'(27);   // x^4+x^3+x+1 feedback of x^13
  localparam logic [M-1:0]    LAST   = M'(N - 1);
  localparam logic [BW-1:0]   LAST_B = BW'(T);
  localparam logic [DEGW-1:0] T_D    = DEGW'(T);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] SEARCH = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // Only ever called with one operand constant, so each use folds to an XOR network.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] acc;
    logic [M-1:0] sh;
    acc = '0;
    sh  = a;
    for (int j = 0; j < M; j++) begin
      if (b[j]) acc = acc ^ sh;
      sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? POLY : '0);
    end
    return acc;
  endfunction

  function automatic logic [M-1:0] alpha_pow(input int e);
    logic [M-1:0] res;
    logic [M-1:0] base;
    int           ee;
    res  = M'(1);
    base = M'(2);
    ee   = e % Q;
    for (int j = 0; j < M; j++) begin
      if (ee[j]) res = gf_mul(res, base);
      base = gf_mul(base, base);
    end
    return res;
  endfunction

  logic [M-1:0]    r       [0:T];
  logic [M-1:0]    scaled  [0:T];
  logic [M-1:0]    stepped [0:T];
  logic [M-1:0]    s;
  logic [BW-1:0]   beat;
  logic [M-1:0]    step;
  logic [DEGW-1:0] roots;
  logic [DEGW-1:0] deg;
  logic            sigma0_zero;
  logic            accept;

  genvar gi;
  for (gi = 0; gi <= T; gi++) begin : g_term
    localparam logic [M-1:0] LOAD_C = alpha_pow(gi * ((1 << M) - N));
    localparam logic [M-1:0] STEP_C = alpha_pow(gi);
    assign scaled[gi]  = gf_mul(load_coef, LOAD_C);
    assign stepped[gi] = gf_mul(r[gi], STEP_C);
  end

  always_comb begin
    s = '0;
    for (int i = 0; i <= T; i++) s = s ^ r[i];
  end

  // Handshake: a beat transfers on any posedge where load_valid && load_ready;
  // load_ready depends only on state, never on load_valid.
  assign load_ready = (state == IDLE) || (state == LOAD);
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      beat        <= '0;
      step        <= '0;
      roots       <= '0;
      deg         <= '0;
      sigma0_zero <= 1'b0;
      err_valid   <= 1'b0;
      err_flag    <= 1'b0;
      err_pos     <= '0;
      done        <= 1'b0;
      fail        <= 1'b0;
      for (int i = 0; i <= T; i++) r[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            for (int i = 0; i <= T; i++)
              if (beat == BW'(i)) r[i] <= scaled[i];
            if (beat == '0) begin
              deg         <= deg_in;
              fail        <= 1'b0;
              roots       <= '0;
              sigma0_zero <= (load_coef == '0);
              state       <= LOAD;
            end
            if (beat == LAST_B) begin
              beat  <= '0;
              step  <= '0;
              state <= SEARCH;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        SEARCH: begin
          for (int i = 0; i <= T; i++) r[i] <= stepped[i];
          err_valid <= 1'b1;
          err_pos   <= LAST - step;
          err_flag  <= (s == '0);
          if ((s == '0) && (roots != '1)) roots <= roots + 1'b1;
          if (step == LAST) state <= DONE;
          else              step  <= step + 1'b1;
        end
        default: begin
          err_valid <= 1'b0;
          err_flag  <= 1'b0;
          done      <= 1'b1;
          fail      <= (deg > T_D) || (roots != deg) || sigma0_zero;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
